// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the two-requester shift arbiter.
package shift_arbiter_pkg;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One pending shift operation as presented by a requester.
    typedef struct packed {
        logic [3:0] a;
        logic       dir;
        logic [1:0] amt;
    } shift_req_t;

endpackage

// File: rtl/shifter_4bit.sv
// 4-bit logical shifter, zero-fill both ways; amount 0 passes A through.
module shifter_4bit
    import shift_arbiter_pkg::*;
(
    input  logic [3:0] A,
    input  logic       dir,
    input  logic [1:0] shift_amt,
    output logic [3:0] out
);

    // Direction select between the two logical shifts.
    always_comb begin
        out = (dir == SHIFT_RIGHT) ? (A >> shift_amt) : (A << shift_amt);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters,
// with a single registered output slot (valid/ready handshake).
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic             req0_dir,
    input  logic [1:0]       req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic             req1_dir,
    input  logic [1:0]       req1_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_id,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    state_t     state_q, state_d;
    logic       last_gnt;
    logic       slot_free;
    logic       grant;
    logic       gnt_id;
    shift_req_t req0, req1, sel;
    logic [3:0] shift_out;

    assign req0 = '{a: req0_a, dir: req0_dir, amt: req0_amt};
    assign req1 = '{a: req1_a, dir: req1_dir, amt: req1_amt};

    // Grant decision; rst_n gating keeps both readies low during reset.
    always_comb begin
        slot_free = (state_q == EMPTY) || out_ready;
        grant     = rst_n && slot_free && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) gnt_id = ~last_gnt;
        else                          gnt_id = req1_valid ? ID_REQ1 : ID_REQ0;
        req0_ready = grant && (gnt_id == ID_REQ0);
        req1_ready = grant && (gnt_id == ID_REQ1);
        sel        = (gnt_id == ID_REQ1) ? req1 : req0;
    end

    shifter_4bit u_shifter (
        .A         (sel.a),
        .dir       (sel.dir),
        .shift_amt (sel.amt),
        .out       (shift_out)
    );

    // Slot FSM: a grant always (re)fills; drain with no grant empties.
    always_comb begin
        state_d = state_q;
        if (grant)          state_d = FULL;
        else if (out_ready) state_d = EMPTY;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    assign out_valid = (state_q == FULL);

    // Result slot and round-robin pointer, loaded only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= ID_REQ0;
            last_gnt <= ID_REQ1;
        end else if (grant) begin
            out_data <= shift_out;
            out_id   <= gnt_id;
            last_gnt <= gnt_id;
        end
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (req0_ready && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (req1_ready && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter (CNT_W=2 so saturation is reachable).
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_dir;
    logic [3:0] req0_a;
    logic [1:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [3:0] req1_a;
    logic [1:0] req1_amt;
    logic       out_valid, out_ready, out_id;
    logic [3:0] out_data;
    logic [1:0] gnt_cnt0, gnt_cnt1;

    int tests = 0;
    int fails = 0;

    shift_arbiter #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_dir(req0_dir), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_dir(req1_dir), .req1_amt(req1_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = 0; req0_dir = 0; req0_amt = 0;
        req1_valid = 0; req1_a = 0; req1_dir = 0; req1_amt = 0;
        out_ready  = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 4'b0000) begin fails++; $display("FAIL reset_data got %b exp 0000", out_data); end
        tests++; if (out_id !== 1'b0) begin fails++; $display("FAIL reset_id got %b exp 0", out_id); end
        tests++; if ({gnt_cnt0, gnt_cnt1} !== 4'b0) begin fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", gnt_cnt0, gnt_cnt1); end
        req0_valid = 1; req1_valid = 1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1; req0_a = 4'b1100; req0_dir = 0; req0_amt = 2'b01;
        out_ready = 1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0;
        tests++; if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 4'b1000}) begin fails++; $display("FAIL single_out got v%b id%b d%b exp v1 id0 d1000", out_valid, out_id, out_data); end
        tests++; if (gnt_cnt0 !== 2'd1) begin fails++; $display("FAIL single_cnt got %0d exp 1", gnt_cnt0); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_contention();
        logic [4:0] exp_seq [3];
        exp_seq[0] = {1'b0, 4'b0011};
        exp_seq[1] = {1'b1, 4'b1100};
        exp_seq[2] = {1'b0, 4'b0011};
        req0_valid = 1; req0_a = 4'b1100; req0_dir = 1; req0_amt = 2'd2;
        req1_valid = 1; req1_a = 4'b0011; req1_dir = 0; req1_amt = 2'd2;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({out_valid, out_id, out_data} !== {1'b1, exp_seq[i]}) begin
                fails++;
                $display("FAIL contention_%0d got v%b id%b d%b exp v1 id%b d%b", i, out_valid, out_id, out_data, exp_seq[i][4], exp_seq[i][3:0]);
            end
        end
        tests++; if ({gnt_cnt0, gnt_cnt1} !== {2'd2, 2'd1}) begin fails++; $display("FAIL contention_cnt got %0d/%0d exp 2/1", gnt_cnt0, gnt_cnt1); end
        idle_inputs();
        out_ready = 1;
        tick();
    endtask

    task automatic test_backpressure();
        req1_valid = 1; req1_a = 4'b0011; req1_dir = 0; req1_amt = 2'd1;
        out_ready = 1;
        tick();
        req1_valid = 0; out_ready = 0;
        req0_valid = 1; req0_a = 4'b1100; req0_dir = 1; req0_amt = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL bp_ready_%0d got %b exp 00", i, {req0_ready, req1_ready}); end
            tick();
            tests++; if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 4'b0110}) begin fails++; $display("FAIL bp_hold_%0d got v%b id%b d%b exp v1 id1 d0110", i, out_valid, out_id, out_data); end
        end
        req0_valid = 0;
        req1_valid = 1; req1_a = 4'b1010; req1_dir = 1; req1_amt = 2'd1;
        out_ready = 1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL bp_release_ready got %b exp 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 0;
        tests++; if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 4'b0101}) begin fails++; $display("FAIL bp_refill got v%b id%b d%b exp v1 id1 d0101", out_valid, out_id, out_data); end
        tick();
    endtask

    task automatic test_amt0_drain();
        req1_valid = 1; req1_a = 4'b1010; req1_dir = 0; req1_amt = 2'd0;
        out_ready = 1;
        tick();
        req1_valid = 0;
        tests++; if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 4'b1010}) begin fails++; $display("FAIL amt0 got v%b id%b d%b exp v1 id1 d1010", out_valid, out_id, out_data); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        req0_valid = 1; req0_a = 4'b0001; req0_dir = 0; req0_amt = 2'd3;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (gnt_cnt0 !== exp_cnt[i]) begin fails++; $display("FAIL sat_%0d got %0d exp %0d", i, gnt_cnt0, exp_cnt[i]); end
        end
        tests++; if (out_data !== 4'b1000) begin fails++; $display("FAIL sat_data got %b exp 1000", out_data); end
        req0_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1; req0_a = 4'b0110; req0_dir = 0; req0_amt = 2'd1;
        out_ready = 0;
        tick();
        req0_valid = 0;
        tests++; if ({out_valid, out_data} !== {1'b1, 4'b1100}) begin fails++; $display("FAIL mid_pre got v%b d%b exp v1 d1100", out_valid, out_data); end
        #2;
        rst_n = 0;
        #1;
        tests++; if ({out_valid, out_data} !== {1'b0, 4'b0000}) begin fails++; $display("FAIL mid_async got v%b d%b exp v0 d0000", out_valid, out_data); end
        req0_valid = 1; req0_a = 4'b1100; req0_dir = 1; req0_amt = 2'd2;
        req1_valid = 1; req1_a = 4'b0011; req1_dir = 0; req1_amt = 2'd2;
        out_ready = 1;
        tick();
        tests++; if ({out_valid, req0_ready, req1_ready} !== 3'b000) begin fails++; $display("FAIL mid_held got v%b r%b%b exp v0 r00", out_valid, req0_ready, req1_ready); end
        @(negedge clk);
        rst_n = 1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL mid_first_ready got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        tests++; if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 4'b0011}) begin fails++; $display("FAIL mid_first_gnt got v%b id%b d%b exp v1 id0 d0011", out_valid, out_id, out_data); end
        idle_inputs();
        out_ready = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_contention();
        test_reset();
        test_backpressure();
        test_amt0_drain();
        test_reset();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout exceeded 20000 time units");
        $fatal(1);
    end

endmodule
